stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 87 ++++++++
 tb/tb_stream_demux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// Demultiplexes one ready/valid input stream into two independent output FIFOs
// (A and B); inSelect picks the destination of each accepted word.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [WIDTH-1:0]         inData,
  input  logic                     inSelect,
  output logic                     outAValid,
  input  logic                     outAReady,
  output logic [WIDTH-1:0]         outAData,
  output logic                     outBValid,
  input  logic                     outBReady,
  output logic [WIDTH-1:0]         outBData,
  output logic [$clog2(DEPTH):0]   countA,
  output logic [$clog2(DEPTH):0]   countB
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic             w_accept;
  logic [1:0]       w_push;
  logic [1:0]       w_out_ready;
  logic [1:0]       w_valid;
  logic [WIDTH-1:0] w_data  [2];
  logic [CW-1:0]    w_count [2];

  // A full FIFO refuses the word even if it is popped this cycle.
  assign inReady  = inSelect ? (w_count[1] != FULL_COUNT) : (w_count[0] != FULL_COUNT);
  assign w_accept = inValid & inReady;
  assign w_push   = {w_accept & inSelect, w_accept & ~inSelect};
  assign w_out_ready = {outBReady, outAReady};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_not_empty;

    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty & w_out_ready[g];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[g], w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // NOTE: storage has no reset; the zero count masks stale contents and
    // outXData is forced to 0 while empty.
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wr_ptr] <= inData;
    end

    assign w_valid[g] = w_not_empty;
    assign w_data[g]  = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign w_count[g] = r_count;
  end

  assign outAValid = w_valid[0];
  assign outBValid = w_valid[1];
  assign outAData  = w_data[0];
  assign outBData  = w_data[1];
  assign countA    = w_count[0];
  assign countB    = w_count[1];

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux with WIDTH=8, DEPTH=2.
module tb_stream_demux;

  logic       clk;
  logic       nReset;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       inSelect;
  logic       outAValid;
  logic       outAReady;
  logic [7:0] outAData;
  logic       outBValid;
  logic       outBReady;
  logic [7:0] outBData;
  logic [1:0] countA;
  logic [1:0] countB;

  int n_tests = 0;
  int n_fail  = 0;

  stream_demux #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .inValid   (inValid),
    .inReady   (inReady),
    .inData    (inData),
    .inSelect  (inSelect),
    .outAValid (outAValid),
    .outAReady (outAReady),
    .outAData  (outAData),
    .outBValid (outBValid),
    .outBReady (outBReady),
    .outBData  (outBData),
    .countA    (countA),
    .countB    (countB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    inValid  = v;
    inSelect = s;
    inData   = d;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; inValid = 1'b0; inSelect = 1'b0; inData = '0;
    outAReady = 1'b0; outBReady = 1'b0;
    #2;
    check("rst_countA", countA, 0);
    check("rst_validA", outAValid, 0);
    check("rst_dataB",  outBData, 0);
    check("rst_ready",  inReady, 1);
    #10 nReset = 1'b1;

    // Idle after reset release
    repeat (3) tick();
    check("idle_validA", outAValid, 0);
    check("idle_validB", outBValid, 0);
    check("idle_countA", countA, 0);
    check("idle_countB", countB, 0);
    check("idle_ready",  inReady, 1);

    // One word to each output, consumers stalled
    drive(1, 0, 8'h11);
    check("one_ready", inReady, 1);
    tick();
    check("one_validA", outAValid, 1);
    drive(1, 1, 8'h22);
    tick();
    check("one_countA", countA, 1);
    check("one_dataA",  outAData, 8'h11);
    check("one_countB", countB, 1);
    check("one_dataB",  outBData, 8'h22);
    drive(0, 0, 8'h00);
    outAReady = 1'b1; outBReady = 1'b1;
    tick();
    check("drain_countA", countA, 0);
    check("drain_countB", countB, 0);
    check("drain_dataA",  outAData, 0);
    outAReady = 1'b0; outBReady = 1'b0;

    // Fill A, observe backpressure, then drain in order
    drive(1, 0, 8'h01); tick();
    drive(1, 0, 8'h02); tick();
    check("full_countA", countA, 2);
    drive(1, 0, 8'h03);
    check("full_ready_a", inReady, 0);
    tick();
    check("full_hold_countA", countA, 2);
    check("full_head",        outAData, 8'h01);
    drive(0, 1, 8'h03);
    check("full_ready_b", inReady, 1);
    drive(1, 0, 8'h03);
    outAReady = 1'b1;
    #1;
    check("full_ready_pop", inReady, 0);
    tick();
    check("pop1_countA", countA, 1);
    check("pop1_dataA",  outAData, 8'h02);
    check("pop1_ready",  inReady, 1);
    tick();
    check("pop2_countA", countA, 1);
    check("pop2_dataA",  outAData, 8'h03);
    check("pop2_countB", countB, 0);
    drive(0, 0, 8'h00);
    tick();
    check("pop3_countA", countA, 0);
    check("pop3_validA", outAValid, 0);
    outAReady = 1'b0;

    // Simultaneous push and pop on a one-entry FIFO
    drive(1, 0, 8'h44); tick();
    check("pp_pre_dataA", outAData, 8'h44);
    drive(1, 0, 8'h55);
    outAReady = 1'b1;
    tick();
    check("pp_countA", countA, 1);
    check("pp_dataA",  outAData, 8'h55);
    drive(0, 0, 8'h00);
    tick();
    check("pp_empty", countA, 0);

    // Alternating stream, both consumers always ready
    outAReady = 1'b1; outBReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, i[0], 8'hA0 + 8'(i));
      check($sformatf("strm_ready%0d", i), inReady, 1);
      tick();
      if (i[0]) begin
        check($sformatf("strm_dataB%0d", i), outBData, 8'hA0 + 8'(i));
        check($sformatf("strm_cntA%0d", i),  countA, 0);
      end else begin
        check($sformatf("strm_dataA%0d", i), outAData, 8'hA0 + 8'(i));
        check($sformatf("strm_cntB%0d", i),  countB, 0);
      end
    end
    drive(0, 0, 8'h00);
    tick();
    check("strm_endA", countA, 0);
    check("strm_endB", countB, 0);
    outAReady = 1'b0; outBReady = 1'b0;

    // Reset mid-transfer discards buffered words
    drive(1, 0, 8'h61); tick();
    drive(1, 0, 8'h62); tick();
    drive(1, 1, 8'h71); tick();
    check("pre_rst_countA", countA, 2);
    check("pre_rst_countB", countB, 1);
    drive(0, 0, 8'h00);
    #1 nReset = 1'b0;
    #1;
    check("mid_rst_countA", countA, 0);
    check("mid_rst_countB", countB, 0);
    check("mid_rst_validA", outAValid, 0);
    check("mid_rst_validB", outBValid, 0);
    check("mid_rst_dataA",  outAData, 0);
    check("mid_rst_ready",  inReady, 1);
    @(negedge clk);
    nReset = 1'b1;
    drive(1, 1, 8'h99);
    tick();
    check("post_rst_countB", countB, 1);
    check("post_rst_dataB",  outBData, 8'h99);
    check("post_rst_countA", countA, 0);
    drive(0, 0, 8'h00);
    outAReady = 1'b1; outBReady = 1'b1;
    tick();
    check("post_rst_emptyB", countB, 0);
    check("post_rst_validA", outAValid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
